// File: rtl/rate_divider.sv
// Enable-pulse generator for the display counter: divides the board clock down to
// 1/2/4 Hz single-cycle ticks, or issues one tick per synchronised step-key press.
module rate_divider #(
    parameter int CLOCK_HZ = 50000000,
    parameter int WIDTH    = 26
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       speed,
    input  logic             pause,
    input  logic             step,
    output logic             tick,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] RELOAD_1HZ = WIDTH'(CLOCK_HZ - 1);
    localparam logic [WIDTH-1:0] RELOAD_2HZ = WIDTH'(CLOCK_HZ / 2 - 1);
    localparam logic [WIDTH-1:0] RELOAD_4HZ = WIDTH'(CLOCK_HZ / 4 - 1);

    function automatic logic [WIDTH-1:0] reload(input logic [1:0] mode);
        case (mode)
            2'b01:   reload = RELOAD_1HZ;
            2'b10:   reload = RELOAD_2HZ;
            2'b11:   reload = RELOAD_4HZ;
            default: reload = '0;
        endcase
    endfunction

    logic             s1_q, s2_q, s3_q;
    logic [1:0]       speed_q, speed_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             step_rise;

    // s1/s2 resynchronise the raw key; s3 is only the history bit for edge detection
    assign step_rise = s2_q & ~s3_q;

    always_comb begin
        speed_d = speed_q;
        count_d = count_q;
        tick_d  = 1'b0;
        if (speed != speed_q) begin
            speed_d = speed;
            count_d = reload(speed);
        end else if (pause) begin
            count_d = count_q;
        end else if (speed_q == 2'b00) begin
            tick_d = step_rise;
        end else if (count_q == '0) begin
            tick_d  = 1'b1;
            count_d = reload(speed_q);
        end else begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            speed_q <= 2'b01;
            count_q <= RELOAD_1HZ;
            tick_q  <= 1'b0;
        end else begin
            s1_q    <= step;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            speed_q <= speed_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick  = tick_q;
    assign count = count_q;

endmodule

// File: tb/tb_rate_divider.sv
// Bench for rate_divider: directed test-plan scenarios followed by random traffic,
// checked against an elapsed-cycles reference model of the divider.
module tb_rate_divider;

    localparam int HZ = 8;
    localparam int W  = 4;

    logic         clk = 1'b0;
    logic         clear;
    logic [1:0]   speed;
    logic         pause;
    logic         step;
    logic         tick;
    logic [W-1:0] count;

    int tests  = 0;
    int failed = 0;

    // Reference model: accepted mode, cycles elapsed in the current period,
    // last tick value and the full history of sampled step values.
    int m_speed;
    int m_phase;
    int m_tick;
    int samples[$];

    always #5 clk = ~clk;

    rate_divider #(.CLOCK_HZ(HZ), .WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .speed (speed),
        .pause (pause),
        .step  (step),
        .tick  (tick),
        .count (count)
    );

    function automatic int period_reload(input int mode);
        if (mode == 0) return 0;
        return HZ / (1 << (mode - 1)) - 1;
    endfunction

    function automatic int exp_count();
        if (m_speed == 0) return 0;
        return period_reload(m_speed) - m_phase;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_speed = 1;
        m_phase = 0;
        m_tick  = 0;
        samples = {0, 0, 0};
    endtask

    task automatic model_edge(input int sp, input int ps, input int st);
        int rise;
        samples.push_back(st);
        if (samples.size() > 8) void'(samples.pop_front());
        // A press is seen two edges after it was first sampled high, if it was low the edge before
        rise = (samples[samples.size()-3] == 1 && samples[samples.size()-4] == 0) ? 1 : 0;
        if (sp != m_speed) begin
            m_speed = sp;
            m_phase = 0;
            m_tick  = 0;
        end else if (ps != 0) begin
            m_tick = 0;
        end else if (m_speed == 0) begin
            m_tick = rise;
        end else begin
            m_phase++;
            if (m_phase == period_reload(m_speed) + 1) begin
                m_tick  = 1;
                m_phase = 0;
            end else begin
                m_tick = 0;
            end
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge(int'(speed), int'(pause), int'(step));
        #1;
        check({tag, "_tick"}, 32'(tick), 32'(m_tick));
        check({tag, "_count"}, 32'(count), 32'(exp_count()));
    endtask

    // Called at posedge+1; pulses clear between edges and checks the asynchronous effect
    task automatic do_clear(input string tag);
        #1 clear = 1'b1;
        #1;
        model_reset();
        check({tag, "_clr_tick"}, 32'(tick), 32'd0);
        check({tag, "_clr_count"}, 32'(count), 32'(HZ - 1));
        #1 clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        speed = 2'b01;
        pause = 1'b0;
        step  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_count", 32'(count), 32'd7);
        clear = 1'b0;

        // 1 Hz after reset: ticks after edges 8, 16, 24
        for (int i = 1; i <= 24; i++) begin
            cyc("s1");
            if (i == 7) check("s1_count_zero", 32'(count), 32'd0);
        end
        check("s1_tick_edge24", 32'(tick), 32'd1);

        // Speed switch at count=5 restarts from the 4 Hz reload
        cyc("s2");
        cyc("s2");
        check("s2_count5", 32'(count), 32'd5);
        speed = 2'b11;
        cyc("s2_change");
        check("s2_reload", 32'(count), 32'd1);
        repeat (6) cyc("s2");

        // Pause at count=2 in 2 Hz mode
        speed = 2'b10;
        cyc("s3_change");
        cyc("s3");
        check("s3_count2", 32'(count), 32'd2);
        pause = 1'b1;
        repeat (5) cyc("s3_pause");
        pause = 1'b0;
        repeat (3) cyc("s3_resume");
        check("s3_tick_after3", 32'(tick), 32'd1);

        // Single-step: held key gives one tick, re-press gives one more
        speed = 2'b00;
        repeat (2) cyc("s4_mode");
        step = 1'b1;
        repeat (10) cyc("s4_hold");
        step = 1'b0;
        repeat (3) cyc("s4_low");
        step = 1'b1;
        cyc("s4_k");
        cyc("s4_k1");
        cyc("s4_k2");
        check("s4_latency", 32'(tick), 32'd1);
        repeat (3) cyc("s4_hold2");
        step = 1'b0;
        repeat (3) cyc("s4_low2");

        // Step pulse during pause is discarded
        pause = 1'b1;
        cyc("s5_pause");
        step = 1'b1;
        repeat (4) cyc("s5_step");
        step = 1'b0;
        cyc("s5_pause");
        pause = 1'b0;
        repeat (6) cyc("s5_after");

        // Async clear while tick is high
        speed = 2'b01;
        for (int i = 0; i < 20 && tick !== 1'b1; i++) cyc("s6_wait");
        check("s6_tick_seen", 32'(tick), 32'd1);
        do_clear("s6");
        repeat (8) cyc("s6_after");
        check("s6_tick_edge8", 32'(tick), 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) speed = 2'($urandom_range(0, 3));
            pause = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) step = ~step;
            cyc("rand");
            if ($urandom_range(0, 99) == 0) do_clear("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
